// File: rtl/weight_load_sequencer_if.sv
// Stream-in and weight_manager register bus for the weight load sequencer.
// master = sequencer side, slave = stream source / weight_manager side.
interface weight_load_sequencer_if #(
    parameter int width    = 16,
    parameter int depth    = 8,
    parameter int bitwidth = 8
);
    localparam int CW = $clog2(width);
    localparam int DW = $clog2(depth);

    logic                       s_valid;
    logic                       s_ready;
    logic signed [bitwidth-1:0] s_data;
    logic signed [bitwidth-1:0] wm_data;
    logic        [CW+DW:0]      wm_inst;
    logic                       wm_exec;
    logic signed [bitwidth-1:0] wm_read;

    modport master (
        input  s_valid, s_data, wm_read,
        output s_ready, wm_data, wm_inst, wm_exec
    );

    modport slave (
        output s_valid, s_data, wm_read,
        input  s_ready, wm_data, wm_inst, wm_exec
    );
endinterface

// File: rtl/weight_load_sequencer.sv
// Walks the full weight table (tap fastest, then channel), issuing one write
// instruction + exec per streamed weight, with optional readback verify.
module weight_load_sequencer #(
    parameter int width    = 16,
    parameter int depth    = 8,
    parameter int bitwidth = 8,
    parameter int EXEC_GAP = 2,
    parameter int READ_LAT = 2,
    parameter int ERR_W    = 8
) (
    input  logic                                     clk,
    input  logic                                     rstb,
    input  logic                                     start,
    input  logic                                     verify_en,
    input  logic                                     abort,
    weight_load_sequencer_if.master                  bus,
    output logic                                     busy,
    output logic                                     done,
    output logic [ERR_W-1:0]                         err_cnt,
    output logic [$clog2(width)+$clog2(depth)-1:0]   err_addr
);
    localparam int CW   = $clog2(width);
    localparam int DW   = $clog2(depth);
    localparam int GMAX = (EXEC_GAP > READ_LAT) ? EXEC_GAP : READ_LAT;
    localparam int GW   = $clog2(GMAX + 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, WR_EXEC, WR_GAP, RD_EXEC, RD_WAIT, CHECK, NEXT
    } state_t;

    state_t                     state_q, state_d;
    logic [CW-1:0]              chan_q, chan_d;
    logic [DW-1:0]              tap_q, tap_d;
    logic [GW-1:0]              cnt_q, cnt_d;
    logic                       verify_q, verify_d;
    logic                       err_seen_q, err_seen_d;
    logic                       s_ready_q, s_ready_d;
    logic signed [bitwidth-1:0] wm_data_q, wm_data_d;
    logic [CW+DW:0]             wm_inst_q, wm_inst_d;
    logic                       wm_exec_q, wm_exec_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic [ERR_W-1:0]           err_cnt_q, err_cnt_d;
    logic [CW+DW-1:0]           err_addr_q, err_addr_d;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_d    = state_q;
        chan_d     = chan_q;
        tap_d      = tap_q;
        cnt_d      = cnt_q;
        verify_d   = verify_q;
        err_seen_d = err_seen_q;
        wm_data_d  = wm_data_q;
        wm_inst_d  = wm_inst_q;
        wm_exec_d  = 1'b0;
        done_d     = 1'b0;
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d    = FETCH;
                    chan_d     = '0;
                    tap_d      = '0;
                    verify_d   = verify_en;
                    err_seen_d = 1'b0;
                    err_cnt_d  = '0;
                    err_addr_d = '0;
                end
            end
            FETCH: begin
                if (bus.s_valid && s_ready_q) begin
                    state_d   = WR_EXEC;
                    wm_data_d = bus.s_data;
                    wm_inst_d = {1'b1, chan_q, tap_q};
                    wm_exec_d = 1'b1;
                end
            end
            WR_EXEC: begin
                state_d = WR_GAP;
                cnt_d   = GW'(EXEC_GAP - 1);
            end
            WR_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (verify_q) begin
                    state_d   = RD_EXEC;
                    wm_inst_d = {1'b0, chan_q, tap_q};
                    wm_exec_d = 1'b1;
                end else begin
                    state_d = NEXT;
                end
            end
            RD_EXEC: begin
                state_d = RD_WAIT;
                cnt_d   = GW'(READ_LAT - 1);
            end
            RD_WAIT: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                else             state_d = CHECK;
            end
            CHECK: begin
                // wm_data still holds the captured weight while the read is in flight
                if (bus.wm_read != wm_data_q) begin
                    err_cnt_d = sat_inc(err_cnt_q);
                    if (!err_seen_q) begin
                        err_seen_d = 1'b1;
                        err_addr_d = {chan_q, tap_q};
                    end
                end
                state_d = NEXT;
            end
            NEXT: begin
                if (tap_q == DW'(depth - 1)) begin
                    tap_d = '0;
                    if (chan_q == CW'(width - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        chan_d  = chan_q + 1'b1;
                        state_d = FETCH;
                    end
                end else begin
                    tap_d   = tap_q + 1'b1;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort leaves the instruction bus untouched so it still shows the last issued op
        if (abort && state_q != IDLE) begin
            state_d   = IDLE;
            wm_exec_d = 1'b0;
            done_d    = 1'b0;
            wm_data_d = wm_data_q;
            wm_inst_d = wm_inst_q;
        end

        s_ready_d = (state_d == FETCH);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q    <= IDLE;
            chan_q     <= '0;
            tap_q      <= '0;
            cnt_q      <= '0;
            verify_q   <= 1'b0;
            err_seen_q <= 1'b0;
            s_ready_q  <= 1'b0;
            wm_data_q  <= '0;
            wm_inst_q  <= '0;
            wm_exec_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            chan_q     <= chan_d;
            tap_q      <= tap_d;
            cnt_q      <= cnt_d;
            verify_q   <= verify_d;
            err_seen_q <= err_seen_d;
            s_ready_q  <= s_ready_d;
            wm_data_q  <= wm_data_d;
            wm_inst_q  <= wm_inst_d;
            wm_exec_q  <= wm_exec_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign bus.s_ready = s_ready_q;
    assign bus.wm_data = wm_data_q;
    assign bus.wm_inst = wm_inst_q;
    assign bus.wm_exec = wm_exec_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_cnt     = err_cnt_q;
    assign err_addr    = err_addr_q;
endmodule

// File: tb/tb_weight_load_sequencer.sv
// Directed bench for weight_load_sequencer: scoreboarded exec stream, echo/corrupt
// readback model, stall, abort and mid-load reset scenarios.
module tb_weight_load_sequencer;
    localparam int W = 16;
    localparam int D = 8;
    localparam int B = 8;
    localparam int BUDGET = 4000;

    typedef struct packed {
        logic       wr;
        logic [6:0] addr;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstb;
    logic       start;
    logic       verify_en;
    logic       abort;
    logic       busy;
    logic       done;
    logic [7:0] err_cnt;
    logic [6:0] err_addr;

    weight_load_sequencer_if #(.width(W), .depth(D), .bitwidth(B)) bus ();

    weight_load_sequencer #(
        .width(W), .depth(D), .bitwidth(B),
        .EXEC_GAP(2), .READ_LAT(2), .ERR_W(8)
    ) dut (
        .clk(clk), .rstb(rstb), .start(start), .verify_en(verify_en), .abort(abort),
        .bus(bus), .busy(busy), .done(done), .err_cnt(err_cnt), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    int   cyc_cnt = 0;
    int   last_wr = -1;
    int   exp_gap = 0;
    int   done_cnt = 0;
    logic [7:0] mem [0:127];
    logic       rd_pend = 1'b0;
    logic [6:0] rd_addr = '0;
    bit         corr_on = 1'b0;
    logic [6:0] corr_a0 = '0;
    logic [6:0] corr_a1 = '0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // weight_manager model: write on write exec, read value appears 2 cycles after read exec
    always @(posedge clk) begin
        if (rd_pend) begin
            bus.wm_read <= mem[rd_addr] ^
                           ((corr_on && (rd_addr == corr_a0 || rd_addr == corr_a1)) ? 8'h01 : 8'h00);
            rd_pend <= 1'b0;
        end
        if (bus.wm_exec && !bus.wm_inst[7]) begin
            rd_pend <= 1'b1;
            rd_addr <= bus.wm_inst[6:0];
        end
        if (bus.wm_exec && bus.wm_inst[7]) mem[bus.wm_inst[6:0]] <= bus.wm_data;
    end

    always @(negedge clk) begin
        if (done) begin
            done_cnt <= done_cnt + 1;
            n_cmp++;
            assert (busy === 1'b0) else begin
                n_err++;
                $error("FAIL busy_at_done got=%0b exp=0", busy);
            end
        end
        if (rstb === 1'b1 && bus.wm_exec === 1'b1) begin
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL exec_unexpected got inst=%h exp=none", bus.wm_inst);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                n_cmp++;
                assert (bus.wm_inst === {e.wr, e.addr}) else begin
                    n_err++;
                    $error("FAIL exec_inst got=%h exp=%h", bus.wm_inst, {e.wr, e.addr});
                end
                if (e.wr) begin
                    n_cmp++;
                    assert (bus.wm_data === e.data) else begin
                        n_err++;
                        $error("FAIL wr_data addr=%0d got=%h exp=%h", e.addr, bus.wm_data, e.data);
                    end
                    if (exp_gap > 0 && last_wr >= 0) begin
                        n_cmp++;
                        assert (cyc_cnt - last_wr == exp_gap) else begin
                            n_err++;
                            $error("FAIL wr_spacing got=%0d exp=%0d", cyc_cnt - last_wr, exp_gap);
                        end
                    end
                    last_wr = cyc_cnt;
                end else begin
                    n_cmp++;
                    assert (cyc_cnt - last_wr == 3) else begin
                        n_err++;
                        $error("FAIL rd_after_wr got=%0d exp=3", cyc_cnt - last_wr);
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"},     32'(busy), 0);
        chk({tag, "_done"},     32'(done), 0);
        chk({tag, "_s_ready"},  32'(bus.s_ready), 0);
        chk({tag, "_wm_exec"},  32'(bus.wm_exec), 0);
        chk({tag, "_wm_inst"},  32'(bus.wm_inst), 0);
        chk({tag, "_wm_data"},  32'(bus.wm_data), 0);
        chk({tag, "_err_cnt"},  32'(err_cnt), 0);
        chk({tag, "_err_addr"}, 32'(err_addr), 0);
    endtask

    // kill_at >= 0 stops after that many beats: abort (kill_rst=0) or async reset in WR_GAP (kill_rst=1)
    task automatic run_load(input bit ver, input int mul, input int off,
                            input int stall_at, input int stall_len,
                            input int kill_at, input bit kill_rst);
        int beat;
        int stall_left;
        int cyc;
        int done0;
        logic [7:0] v;
        done0   = done_cnt;
        exp_gap = (stall_len > 0) ? 0 : (ver ? 9 : 5);
        last_wr = -1;
        @(negedge clk);
        start = 1'b1;
        verify_en = ver;
        @(negedge clk);
        start = 1'b0;
        verify_en = 1'b0;
        chk("busy_after_start", 32'(busy), 1);
        chk("err_cnt_cleared", 32'(err_cnt), 0);
        chk("err_addr_cleared", 32'(err_addr), 0);
        beat = 0;
        stall_left = stall_len;
        cyc = 0;
        while (beat < 128 && cyc < BUDGET) begin
            if (kill_at >= 0 && beat == kill_at) break;
            v = 8'(beat * mul + off);
            if (beat == stall_at && stall_left > 0) begin
                bus.s_valid = 1'b0;
                stall_left--;
                if (stall_left == 0) chk("stall_holds_fetch", 32'(bus.s_ready), 1);
            end else begin
                bus.s_valid = 1'b1;
                bus.s_data  = v;
            end
            if (bus.s_valid && bus.s_ready) begin
                sb.push_back('{wr: 1'b1, addr: 7'(beat), data: v});
                if (ver) sb.push_back('{wr: 1'b0, addr: 7'(beat), data: v});
                beat++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.s_valid = 1'b0;
        if (kill_at >= 0) begin
            if (!kill_rst) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                chk("abort_busy", 32'(busy), 0);
                chk("abort_s_ready", 32'(bus.s_ready), 0);
            end else begin
                @(negedge clk);
                rstb = 1'b0;
                #1;
                chk_zero_outputs("midload_reset");
                @(negedge clk);
                rstb = 1'b1;
            end
            repeat (20) @(negedge clk);
            chk("kill_no_done", 32'(done_cnt), 32'(done0));
            chk("kill_pending", 32'(sb.size()), ver ? 1 : 0);
            sb.delete();
        end else begin
            while (done !== 1'b1 && cyc < BUDGET) begin
                @(negedge clk);
                cyc++;
            end
            chk("done_seen", 32'(done), 1);
            @(negedge clk);
            chk("done_one_cycle", 32'(done), 0);
            chk("busy_fell", 32'(busy), 0);
            chk("done_count", 32'(done_cnt), 32'(done0 + 1));
            chk("all_execs_seen", 32'(sb.size()), 0);
            chk("beats_used", 32'(beat), 128);
        end
    endtask

    initial begin
        rstb = 1'b0;
        start = 1'b0;
        verify_en = 1'b0;
        abort = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.wm_read = '0;
        repeat (2) @(negedge clk);
        chk_zero_outputs("reset");
        rstb = 1'b1;
        @(negedge clk);

        // plain load, data = beat index
        run_load(1'b0, 1, 0, -1, 0, -1, 1'b0);
        chk("t1_err_cnt", 32'(err_cnt), 0);

        // verify with clean echo
        run_load(1'b1, 3, 5, -1, 0, -1, 1'b0);
        chk("t2_err_cnt", 32'(err_cnt), 0);

        // verify with {3,5} and {9,0} corrupted
        corr_on = 1'b1;
        corr_a0 = 7'd29;
        corr_a1 = 7'd72;
        run_load(1'b1, 7, 100, -1, 0, -1, 1'b0);
        chk("t3_err_cnt", 32'(err_cnt), 2);
        chk("t3_err_addr", 32'(err_addr), 29);

        // stall 10 cycles at beat 40
        corr_on = 1'b0;
        run_load(1'b0, 2, 1, 40, 10, -1, 1'b0);

        // aborted verify load with one corrupted entry, then a fresh load
        corr_on = 1'b1;
        corr_a0 = 7'd3;
        corr_a1 = 7'd3;
        run_load(1'b1, 1, 9, -1, 0, 20, 1'b0);
        chk("t5_err_cnt_kept", 32'(err_cnt), 1);
        chk("t5_err_addr_kept", 32'(err_addr), 3);
        corr_on = 1'b0;
        run_load(1'b0, 1, 50, -1, 0, -1, 1'b0);
        chk("t5_err_cnt_new", 32'(err_cnt), 0);

        // async reset during WR_GAP, then a full load
        run_load(1'b0, 1, 0, -1, 0, 30, 1'b1);
        run_load(1'b0, 5, 1, -1, 0, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
